// File: rtl/rs_exerciser_pkg.sv
// Shared types and per-phase constants for the gated RS latch exerciser.
// Drive pairs are {S,R}; expected latch pairs are {Q,Q_L}.
package rs_exerciser_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SET     = 3'd1,
    ST_RESET   = 3'd2,
    ST_HOLD    = 3'd3,
    ST_ILLEGAL = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  localparam logic [1:0] PHASE_SET     = 2'd0;
  localparam logic [1:0] PHASE_RESET   = 2'd1;
  localparam logic [1:0] PHASE_HOLD    = 2'd2;
  localparam logic [1:0] PHASE_ILLEGAL = 2'd3;

  localparam logic [1:0] DRV_SET     = 2'b10;
  localparam logic [1:0] DRV_RESET   = 2'b01;
  localparam logic [1:0] DRV_HOLD    = 2'b00;
  localparam logic [1:0] DRV_ILLEGAL = 2'b11;
  localparam logic [1:0] DRV_OFF     = 2'b00;

  // HOLD expects the value left behind by the RESET phase.
  localparam logic [1:0] EXP_SET     = 2'b10;
  localparam logic [1:0] EXP_RESET   = 2'b01;
  localparam logic [1:0] EXP_HOLD    = 2'b01;
  localparam logic [1:0] EXP_ILLEGAL = 2'b00;

  function automatic logic is_run_state(state_t st);
    return (st == ST_SET) || (st == ST_RESET) || (st == ST_HOLD) || (st == ST_ILLEGAL);
  endfunction

  function automatic state_t next_phase_state(state_t st);
    case (st)
      ST_SET:     return ST_RESET;
      ST_RESET:   return ST_HOLD;
      ST_HOLD:    return ST_ILLEGAL;
      ST_ILLEGAL: return ST_DONE;
      default:    return ST_IDLE;
    endcase
  endfunction

  function automatic logic [1:0] phase_code(state_t st);
    case (st)
      ST_RESET:   return PHASE_RESET;
      ST_HOLD:    return PHASE_HOLD;
      ST_ILLEGAL: return PHASE_ILLEGAL;
      default:    return PHASE_SET;
    endcase
  endfunction

  function automatic logic [1:0] drive_for(state_t st);
    case (st)
      ST_SET:     return DRV_SET;
      ST_RESET:   return DRV_RESET;
      ST_HOLD:    return DRV_HOLD;
      ST_ILLEGAL: return DRV_ILLEGAL;
      default:    return DRV_OFF;
    endcase
  endfunction

  function automatic logic [1:0] expect_for(state_t st);
    case (st)
      ST_SET:   return EXP_SET;
      ST_RESET: return EXP_RESET;
      ST_HOLD:  return EXP_HOLD;
      default:  return EXP_ILLEGAL;
    endcase
  endfunction

endpackage

// File: rtl/rs_latch_exerciser_sync2.sv
// Two-flop synchronizer for one asynchronous latch output.
module sync2 (
  input  logic clk,
  input  logic srst,
  input  logic d,
  output logic q
);

  logic meta_reg;
  logic sync_reg;

  always_ff @(posedge clk) begin
    if (srst) begin
      meta_reg <= 1'b0;
      sync_reg <= 1'b0;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/rs_latch_exerciser.sv
// Drives a gated RS latch through SET/RESET/HOLD/ILLEGAL phases and checks
// the synchronized Q/Q_L at the end of every clean ENA half-window.
module rs_latch_exerciser
  import rs_exerciser_pkg::*;
#(
  parameter int PHASE_CYCLES  = 500,
  parameter int ENA_HALF      = 95,
  parameter bit CHECK_ILLEGAL = 1'b1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  input  logic       Q,
  input  logic       Q_L,
  output logic       ENA,
  output logic       R,
  output logic       S,
  output logic [1:0] PHASE,
  output logic       BUSY,
  output logic       DONE,
  output logic       ERR,
  output logic [7:0] ERR_CNT
);

  localparam int PC_W = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
  localparam int EH_W = (ENA_HALF > 1) ? $clog2(ENA_HALF) : 1;
  localparam logic [PC_W-1:0] PC_LAST = PC_W'(PHASE_CYCLES - 1);
  localparam logic [EH_W-1:0] EH_LAST = EH_W'(ENA_HALF - 1);

  state_t          state_reg, state_next;
  logic [PC_W-1:0] phase_cnt_reg, phase_cnt_next;
  logic [EH_W-1:0] ena_cnt_reg, ena_cnt_next;
  logic            ena_reg, ena_next;
  logic            s_reg, r_reg;
  logic [1:0]      drive_next;
  logic            clean_reg, clean_next;
  logic            err_reg, err_next;
  logic [7:0]      err_cnt_reg, err_cnt_next;
  logic [1:0]      latch_raw, latch_sync;
  logic            in_run, phase_end, ena_end, check_en, mismatch;

  // Bit 1 carries Q, bit 0 carries Q_L, matching the expected-pair layout.
  assign latch_raw = {Q, Q_L};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_sync
      sync2 u_sync (
        .clk  (CLK),
        .srst (RST),
        .d    (latch_raw[gi]),
        .q    (latch_sync[gi])
      );
    end
  endgenerate

  always_comb begin
    state_next     = state_reg;
    phase_cnt_next = phase_cnt_reg;
    ena_cnt_next   = ena_cnt_reg;
    ena_next       = ena_reg;
    clean_next     = clean_reg;
    err_next       = err_reg;
    err_cnt_next   = err_cnt_reg;

    in_run    = is_run_state(state_reg);
    phase_end = in_run && (phase_cnt_reg == PC_LAST);
    ena_end   = (ena_cnt_reg == EH_LAST);
    check_en  = in_run && ena_end && clean_reg;
    if ((state_reg == ST_ILLEGAL) && (!CHECK_ILLEGAL || !ena_reg)) begin
      check_en = 1'b0;
    end
    mismatch = check_en && (latch_sync != expect_for(state_reg));

    case (state_reg)
      ST_IDLE, ST_DONE: begin
        if (START) begin
          state_next     = ST_SET;
          phase_cnt_next = '0;
          ena_cnt_next   = '0;
          ena_next       = 1'b1;
          clean_next     = 1'b1;
          err_next       = 1'b0;
          err_cnt_next   = '0;
        end
      end
      default: begin
        phase_cnt_next = phase_end ? '0 : phase_cnt_reg + PC_W'(1);
        if (phase_end) begin
          state_next = next_phase_state(state_reg);
        end
        // ENA keeps its own cadence; phase edges never realign it.
        ena_cnt_next = ena_end ? '0 : ena_cnt_reg + EH_W'(1);
        ena_next     = ena_end ? ~ena_reg : ena_reg;
        // A window start wins over a coincident phase change: the window is wholly in the new phase.
        clean_next   = ena_end ? 1'b1 : (phase_end ? 1'b0 : clean_reg);
        if (mismatch) begin
          err_next = 1'b1;
          if (err_cnt_reg != 8'hFF) begin
            err_cnt_next = err_cnt_reg + 8'd1;
          end
        end
        if (state_next == ST_DONE) begin
          ena_next     = 1'b0;
          ena_cnt_next = '0;
          clean_next   = 1'b0;
        end
      end
    endcase

    drive_next = drive_for(state_next);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg     <= ST_IDLE;
      phase_cnt_reg <= '0;
      ena_cnt_reg   <= '0;
      ena_reg       <= 1'b0;
      s_reg         <= 1'b0;
      r_reg         <= 1'b0;
      clean_reg     <= 1'b0;
      err_reg       <= 1'b0;
      err_cnt_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      phase_cnt_reg <= phase_cnt_next;
      ena_cnt_reg   <= ena_cnt_next;
      ena_reg       <= ena_next;
      s_reg         <= drive_next[1];
      r_reg         <= drive_next[0];
      clean_reg     <= clean_next;
      err_reg       <= err_next;
      err_cnt_reg   <= err_cnt_next;
    end
  end

  assign ENA     = ena_reg;
  assign S       = s_reg;
  assign R       = r_reg;
  assign PHASE   = phase_code(state_reg);
  assign BUSY    = in_run;
  assign DONE    = (state_reg == ST_DONE);
  assign ERR     = err_reg;
  assign ERR_CNT = err_cnt_reg;

endmodule

// File: tb/tb_rs_latch_exerciser.sv
// Three exerciser configurations share START/RST; each drives its own behavioural latch load.
// Expected per-run ERR/ERR_CNT come from a window-level reference model.
module tb_rs_latch_exerciser;

  localparam int NDUT = 3;
  localparam int EH   = 5;

  typedef struct {
    bit       err;
    bit [7:0] cnt;
  } exp_t;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic start = 1'b0;
  int   fault = 0;   // 0 good latch, 1 Q stuck at 0, 2 Q=Q_L=1 when S=R=ENA=1

  bit         q_in[NDUT];
  bit         ql_in[NDUT];
  bit         lq[NDUT];
  bit         lql[NDUT];
  logic       ena_w[NDUT], r_w[NDUT], s_w[NDUT], busy_w[NDUT], done_w[NDUT], err_w[NDUT];
  logic [1:0] phase_w[NDUT];
  logic [7:0] cnt_w[NDUT];

  exp_t exp_q[NDUT][$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  function automatic int pc_of(int i);
    return (i == 1) ? 43 : 40;
  endfunction

  function automatic bit ci_of(int i);
    return i != 2;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < NDUT; gi++) begin : g_dut
      rs_latch_exerciser #(
        .PHASE_CYCLES  ((gi == 1) ? 43 : 40),
        .ENA_HALF      (EH),
        .CHECK_ILLEGAL ((gi == 2) ? 1'b0 : 1'b1)
      ) u_dut (
        .CLK     (clk),
        .RST     (rst),
        .START   (start),
        .Q       (q_in[gi]),
        .Q_L     (ql_in[gi]),
        .ENA     (ena_w[gi]),
        .R       (r_w[gi]),
        .S       (s_w[gi]),
        .PHASE   (phase_w[gi]),
        .BUSY    (busy_w[gi]),
        .DONE    (done_w[gi]),
        .ERR     (err_w[gi]),
        .ERR_CNT (cnt_w[gi])
      );
    end
  endgenerate

  // Latch load: responds half a cycle after the registered drives change.
  always @(negedge clk) begin
    for (int i = 0; i < NDUT; i++) begin
      if (ena_w[i] === 1'b1) begin
        if (s_w[i] === 1'b1 && r_w[i] === 1'b1) begin
          lq[i]  = (fault == 2);
          lql[i] = (fault == 2);
        end else if (s_w[i] === 1'b1) begin
          lq[i]  = 1'b1;
          lql[i] = 1'b0;
        end else if (r_w[i] === 1'b1) begin
          lq[i]  = 1'b0;
          lql[i] = 1'b1;
        end
      end
      q_in[i]  = (fault == 1) ? 1'b0 : lq[i];
      ql_in[i] = lql[i];
    end
  end

  // Reference: walk the run cycle by cycle, then judge each ENA half-window as a whole.
  function automatic exp_t predict(int pc, bit ci, int f);
    bit [1:0] lat = 2'b00;
    bit [1:0] obs[0:255];
    bit [1:0] want;
    int       n = 0;
    int       ph;
    int       first_c;
    int       last_c;
    bit       en;
    exp_t     e;
    for (int c = 0; c < 4 * pc; c++) begin
      ph = c / pc;
      en = ((c / EH) % 2) == 0;
      if (en) begin
        if (ph == 3)      lat = (f == 2) ? 2'b11 : 2'b00;
        else if (ph == 0) lat = 2'b10;
        else if (ph == 1) lat = 2'b01;
      end
      obs[c] = (f == 1) ? {1'b0, lat[0]} : lat;
    end
    for (int w = 0; w * EH + EH - 1 < 4 * pc; w++) begin
      first_c = w * EH;
      last_c  = w * EH + EH - 1;
      ph      = last_c / pc;
      if (first_c / pc != ph) continue;
      if (ph == 3 && (!ci || (w % 2) != 0)) continue;
      case (ph)
        0:       want = 2'b10;
        3:       want = 2'b00;
        default: want = 2'b01;
      endcase
      if (obs[last_c - 2] != want) n++;
    end
    e.err = (n > 0);
    e.cnt = (n > 255) ? 8'd255 : 8'(n);
    return e;
  endfunction

  // Monitor: per-cycle trace during BUSY, scoreboard pop when BUSY drops.
  bit   rst_edge;
  bit   in_run[NDUT];
  bit   busy_prev[NDUT];
  int   k[NDUT];
  int   bad[NDUT];
  int   bad_k[NDUT];
  int   mon_pc, mon_ph;
  bit   mon_en, mon_s, mon_r;
  exp_t mon_e;

  always @(posedge clk) rst_edge <= rst;

  always @(negedge clk) begin
    for (int i = 0; i < NDUT; i++) begin
      mon_pc = pc_of(i);
      if (rst_edge) begin
        checks++;
        if ({ena_w[i], r_w[i], s_w[i], phase_w[i], busy_w[i], done_w[i], err_w[i], cnt_w[i]} !== 15'd0) begin
          failures++;
          $display("FAIL reset_state dut%0d: got ena=%b r=%b s=%b phase=%0d busy=%b done=%b err=%b err_cnt=%0d, want all 0",
                   i, ena_w[i], r_w[i], s_w[i], phase_w[i], busy_w[i], done_w[i], err_w[i], cnt_w[i]);
        end
        in_run[i] = 1'b0;
      end else begin
        if (busy_w[i] === 1'b1 && !busy_prev[i]) begin
          in_run[i] = 1'b1;
          k[i]      = 0;
          bad[i]    = 0;
          bad_k[i]  = 0;
        end
        if (in_run[i]) begin
          if (busy_w[i] === 1'b1) begin
            mon_ph = k[i] / mon_pc;
            mon_en = ((k[i] / EH) % 2) == 0;
            mon_s  = (mon_ph == 0) || (mon_ph == 3);
            mon_r  = (mon_ph == 1) || (mon_ph == 3);
            if (k[i] >= 4 * mon_pc || phase_w[i] !== mon_ph[1:0] || ena_w[i] !== mon_en ||
                s_w[i] !== mon_s || r_w[i] !== mon_r || done_w[i] !== 1'b0 ||
                (k[i] == 0 && (err_w[i] !== 1'b0 || cnt_w[i] !== 8'd0))) begin
              if (bad[i] == 0) bad_k[i] = k[i];
              bad[i]++;
            end
            k[i]++;
          end else begin
            in_run[i] = 1'b0;
            checks++;
            if (done_w[i] !== 1'b1 || k[i] != 4 * mon_pc) begin
              failures++;
              $display("FAIL run_length dut%0d: got %0d busy cycles done=%b, want %0d cycles done=1",
                       i, k[i], done_w[i], 4 * mon_pc);
            end
            checks++;
            if (bad[i] != 0) begin
              failures++;
              $display("FAIL drive_trace dut%0d: got %0d wrong cycles (first at %0d), want 0", i, bad[i], bad_k[i]);
            end
            checks++;
            if (exp_q[i].size() == 0) begin
              failures++;
              $display("FAIL scoreboard dut%0d: got a completed run, want no run", i);
            end else begin
              mon_e = exp_q[i].pop_front();
              $display("run dut%0d: err=%b err_cnt=%0d expected err=%b err_cnt=%0d",
                       i, err_w[i], cnt_w[i], mon_e.err, mon_e.cnt);
              if (err_w[i] !== mon_e.err) begin
                failures++;
                $display("FAIL err_flag dut%0d: got %b, want %b", i, err_w[i], mon_e.err);
              end
              checks++;
              if (cnt_w[i] !== mon_e.cnt) begin
                failures++;
                $display("FAIL err_cnt dut%0d: got %0d, want %0d", i, cnt_w[i], mon_e.cnt);
              end
            end
          end
        end
      end
      busy_prev[i] = (busy_w[i] === 1'b1);
    end
  end

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_all();
    for (int i = 0; i < NDUT; i++) exp_q[i].push_back(predict(pc_of(i), ci_of(i), fault));
  endtask

  task automatic wait_done(int idx_all);   // idx_all < 0 waits for every instance
    int t = 0;
    bit ok = 1'b0;
    while (!ok) begin
      if (idx_all < 0) ok = (done_w[0] === 1'b1) && (done_w[1] === 1'b1) && (done_w[2] === 1'b1);
      else             ok = (done_w[idx_all] === 1'b1);
      if (!ok) begin
        tick(1);
        t++;
        if (t > 1000) begin
          $display("FAIL run_timeout: got no DONE after %0d cycles, want DONE", t);
          $fatal(1, "run timeout");
        end
      end
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic run(int f);
    fault = f;
    tick(1);
    push_all();
    pulse_start();
    wait_done(-1);
    tick(2);
  endtask

  task automatic abort(int f, int at);
    fault = f;
    tick(1);
    push_all();
    pulse_start();
    tick(at);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    for (int i = 0; i < NDUT; i++) exp_q[i].delete();
    tick(2);
  endtask

  // START held through DONE: every instance restarts once, then START drops.
  task automatic held_run(int f);
    fault = f;
    tick(1);
    push_all();
    push_all();
    start = 1'b1;
    tick(1);
    wait_done(1);
    tick(1);
    start = 1'b0;
    wait_done(-1);
    tick(2);
  endtask

  initial begin
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(2);
    run(0);
    run(1);
    run(0);
    run(2);
    abort(0, 70);
    run(0);
    held_run(1);
    for (int n = 0; n < 10; n++) begin
      if ($urandom_range(0, 3) == 0) abort(int'($urandom_range(0, 2)), int'($urandom_range(2, 170)));
      else                           run(int'($urandom_range(0, 2)));
      tick(int'($urandom_range(1, 4)));
    end
    tick(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
